// File: rtl/hex_display_pkg.sv
// Shared types and glyph table for the multiplexed hex display.
package hex_display_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // All segments off (active-low).
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,  // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  nibble_t nibble_i,
  input  logic    blank_i,
  output seg_t    seg_o
);

  // Blank wins over the glyph lookup.
  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display scanner with a tear-free load handshake
// and optional leading-zero blanking.
// Optional digit blinking is compiled in with HEX_SCAN_BLINK_EN.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 1000
`ifdef HEX_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  input  logic [4*NUM_DIGITS-1:0] ld_value,
  output logic                    ld_ready,
  input  logic                    lz_blank,
`ifdef HEX_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int unsigned PcntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PcntW-1:0]        pcnt_q, pcnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] pend_buf_q, pend_buf_d;
  logic                    pending_q, pending_d;
  seg_t                    seg_q;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q;

  logic    tick, boundary, accept;
  nibble_t cur_nib;
  logic    cur_blank, blink_off;
  logic [IdxW-1:0] msnz;
  seg_t    seg_dec;

  assign ld_ready = ~pending_q;
  assign accept   = ld_valid & ~pending_q;

  // Prescaler and digit index advance; boundary marks the end of a frame.
  always_comb begin
    tick     = (pcnt_q == PcntW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IdxW'(NUM_DIGITS - 1));
    pcnt_d   = tick ? '0 : pcnt_q + PcntW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IdxW'(1);
    end
  end

  // Load handshake: one pending slot, committed to the shadow only at a boundary.
  always_comb begin
    pending_d  = pending_q;
    pend_buf_d = pend_buf_q;
    shadow_d   = shadow_q;
    if (boundary && pending_q) begin
      shadow_d  = pend_buf_q;
      pending_d = 1'b0;
    end else if (accept) begin
      pend_buf_d = ld_value;
      pending_d  = 1'b1;
    end
  end

`ifdef HEX_SCAN_BLINK_EN
  localparam int unsigned BfW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BfW-1:0] fcnt_q;
  logic           phase_on_q;
  logic           cur_mask;

  // Count boundaries and flip the blink phase every BLINK_FRAMES of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q     <= '0;
      phase_on_q <= 1'b1;
    end else if (boundary) begin
      if (fcnt_q == BfW'(BLINK_FRAMES - 1)) begin
        fcnt_q     <= '0;
        phase_on_q <= ~phase_on_q;
      end else begin
        fcnt_q <= fcnt_q + BfW'(1);
      end
    end
  end

  // Blink mask bit of the digit currently being scanned.
  always_comb begin
    cur_mask = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_mask = blink_mask[k];
      end
    end
  end

  assign blink_off = cur_mask & ~phase_on_q;
`else
  assign blink_off = 1'b0;
`endif

  // Select the scanned nibble, find the top nonzero digit and form one-hot select.
  always_comb begin
    cur_nib = '0;
    msnz    = '0;
    sel_d   = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib  = shadow_q[4*k +: 4];
        sel_d[k] = 1'b1;
      end
      if (shadow_q[4*k +: 4] != 4'h0) begin
        msnz = IdxW'(k);
      end
    end
    // Digit 0 can never be above msnz, so it always shows.
    cur_blank = (lz_blank && (idx_q > msnz)) || blink_off;
  end

  hex_seg_decode u_decode (
    .nibble_i (cur_nib),
    .blank_i  (cur_blank),
    .seg_o    (seg_dec)
  );

  // Scan, handshake and shadow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_buf_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_buf_q <= pend_buf_d;
      pending_q  <= pending_d;
    end
  end

  // Registered outputs, one cycle behind the index; frame_start marks digit 0's first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      sel_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= seg_dec;
      sel_q <= sel_d;
      fs_q  <= (pcnt_q == '0) && (idx_q == '0);
    end
  end

  assign seg         = seg_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with NUM_DIGITS=4, SCAN_DIV=4.
// Blink checks run only when HEX_SCAN_BLINK_EN is defined.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_value = '0;
  logic        ld_ready;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_start;
`ifdef HEX_SCAN_BLINK_EN
  logic [3:0]  blink_mask_r = 4'b0000;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hex_display_scan #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4)
`ifdef HEX_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (2)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_value    (ld_value),
    .ld_ready    (ld_ready),
    .lz_blank    (lz_blank),
`ifdef HEX_SCAN_BLINK_EN
    .blink_mask  (blink_mask_r),
`endif
    .seg         (seg),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Find the next frame_start, then check each digit's first cycle.
  task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp_seg [4];
    logic [3:0] one;
    int n;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    one = 4'b0001;
    n = 0;
    step();
    while (!frame_start && n < 40) begin
      step();
      n++;
    end
    if (!frame_start) begin
      check_eq({tag, "_timeout"}, 32'(frame_start), 32'd1);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) step();
      check_eq($sformatf("%s_sel%0d", tag, k), 32'(digit_sel), 32'(one << k));
      check_eq($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp_seg[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] one;
    one = 4'b0001;

    // Reset state.
    step();
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_sel", 32'(digit_sel), 32'h0);
    check_eq("rst_fs", 32'(frame_start), 32'h0);
    check_eq("rst_ready", 32'(ld_ready), 32'h1);

    // Scan sequence: 4 cycles per digit, frame_start every 16 cycles.
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check_eq($sformatf("scan_sel_c%0d", i), 32'(digit_sel), 32'(one << (((i - 1) / 4) % 4)));
      check_eq($sformatf("scan_fs_c%0d", i), 32'(frame_start), 32'(((i - 1) % 16) == 0));
      if (i == 1) check_eq("scan_seg_c1", 32'(seg), 32'h40);
    end
    check_eq("scan_ready", 32'(ld_ready), 32'h1);

    // Mid-frame load of 1234.
    repeat (4) step();
    ld_valid = 1'b1;
    ld_value = 16'h1234;
    step();
    ld_valid = 1'b0;
    ld_value = 16'hFFFF;
    check_eq("load_ready_low", 32'(ld_ready), 32'h0);
    repeat (8) step();
    check_eq("load_old_sel3", 32'(digit_sel), 32'h8);
    check_eq("load_old_seg3", 32'(seg), 32'h40);
    check_frame("load_new", 7'h79, 7'h24, 7'h30, 7'h19);
    check_eq("load_ready_back", 32'(ld_ready), 32'h1);

    // Leading-zero blanking on 0050, then off.
    lz_blank = 1'b1;
    ld_valid = 1'b1;
    ld_value = 16'h0050;
    step();
    ld_valid = 1'b0;
    check_frame("lz_on", 7'h7F, 7'h7F, 7'h12, 7'h40);
    lz_blank = 1'b0;
    check_frame("lz_off", 7'h40, 7'h40, 7'h12, 7'h40);

    // Load accepted in the boundary cycle (pcnt=3, idx=3) commits one frame later.
    repeat (2) step();
    ld_valid = 1'b1;
    ld_value = 16'hBEEF;
    step();
    ld_valid = 1'b0;
    check_eq("bnd_ready_low", 32'(ld_ready), 32'h0);
    check_frame("bnd_old", 7'h40, 7'h40, 7'h12, 7'h40);
    check_frame("bnd_new", 7'h03, 7'h06, 7'h06, 7'h0E);
    check_eq("bnd_ready_back", 32'(ld_ready), 32'h1);

    // Reset while a load is pending.
    ld_valid = 1'b1;
    ld_value = 16'h1111;
    step();
    ld_valid = 1'b0;
    check_eq("rstp_ready_low", 32'(ld_ready), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rstp_seg", 32'(seg), 32'h7F);
    check_eq("rstp_sel", 32'(digit_sel), 32'h0);
    check_eq("rstp_fs", 32'(frame_start), 32'h0);
    check_eq("rstp_ready", 32'(ld_ready), 32'h1);
    repeat (2) step();
    reset = 1'b0;
    step();
    check_eq("rel_sel", 32'(digit_sel), 32'h1);
    check_eq("rel_seg", 32'(seg), 32'h40);
    check_eq("rel_fs", 32'(frame_start), 32'h1);
    check_frame("rel_f2", 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("rel_f3", 7'h40, 7'h40, 7'h40, 7'h40);
    check_eq("rel_ready", 32'(ld_ready), 32'h1);

`ifdef HEX_SCAN_BLINK_EN
    // Blink digit 0 with a 2-frame phase.
    reset = 1'b1;
    step();
    blink_mask_r = 4'b0001;
    reset = 1'b0;
    check_frame("blink_f1", 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("blink_f2", 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("blink_f3", 7'h40, 7'h40, 7'h40, 7'h7F);
    check_frame("blink_f4", 7'h40, 7'h40, 7'h40, 7'h7F);
    check_frame("blink_f5", 7'h40, 7'h40, 7'h40, 7'h40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
